iter_divider: RTL and testbench
===============================

// Module: iter_divider
//
// PURPOSE
//   Multi-cycle radix-2 restoring divider: the responder on the execute stage's divide handshake.
//   Execute holds `triggered` high with operands stable and stalls while `is_finished` is low.
//   Returns RV32M DIV/DIVU/REM/REMU quotient and remainder, including RISC-V div-by-zero and overflow results.
//   Sits inside the execute stage beside the ALU; has no register-file or memory access.
//
// PARAMETERS
//   DATA_WIDTH   32   operand/result width; iteration count = DATA_WIDTH
//
// PORTS
//   clk           in   1           single clock, rising edge
//   rst_n         in   1           synchronous reset, active-low
//   triggered     in   1           divide request; held high by execute for the whole operation
//   hold          in   1           execute frozen by another stall source; keeps the result presented
//   dividend      in   DATA_WIDTH  rs1 / op1; sampled only at start
//   divisor       in   DATA_WIDTH  rs2 / op2; sampled only at start
//   is_unsigned   in   1           1 = DIVU/REMU, 0 = DIV/REM; sampled at start
//   quotient      out  DATA_WIDTH  registered quotient
//   remainder     out  DATA_WIDTH  registered remainder
//   is_finished   out  1           registered; high only in DONE
//   busy          out  1           high in BUSY
//
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=IDLE; quotient=0, remainder=0, is_finished=0, busy=0. Reset overrides any state, including mid-operation.
//   - FSM states: IDLE, BUSY, DONE.
//   - IDLE, triggered=1 (start, cycle 0):
//       - Latch the operands and is_unsigned.
//       - Latch sign flags (signed mode only): q_neg = sign(dividend) ^ sign(divisor); r_neg = sign(dividend).
//       - Load magnitudes |dividend| and |divisor|; in unsigned mode the raw values are the magnitudes.
//       - Clear the partial remainder and the 6-bit iteration counter, then go to BUSY.
//   - Start-cycle special cases (go straight to DONE; is_finished is high in cycle 1):
//       - divisor==0: quotient = all-ones, remainder = dividend.
//       - signed, dividend==0x80000000 and divisor==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
//   - BUSY:
//       - Each cycle, shift {rem,quo} left 1, bringing in the dividend MSB.
//       - If rem >= |divisor|: subtract, and set the quotient LSB.
//       - After DATA_WIDTH iterations (cycles 1..32), apply sign fix-up (negate q if q_neg, negate r if r_neg), register the outputs and go to DONE.
//       - Normal latency: start in cycle 0, is_finished=1 in cycle 33.
//   - DONE:
//       - is_finished=1 with quotient/remainder stable.
//       - If hold=1, stay in DONE; otherwise go to IDLE next cycle.
//       - Back-to-back divide: triggered still high in IDLE starts a new operation. No restart occurs from DONE.
//   - Abort (flush): triggered=0 while in BUSY -> IDLE next cycle. is_finished is not asserted; the outputs keep their prior values.
//   - triggered=0 while in DONE: leave per the hold rule; no error.
//   - Operand changes during BUSY are ignored because the operands were latched at start.
//   - Width rules:
//       - Magnitudes are DATA_WIDTH bits unsigned; |0x80000000| = 0x80000000, which is handled correctly as unsigned.
//       - The partial remainder is DATA_WIDTH+1 bits for the compare/subtract.
//   - Outputs are driven from registers only; there is no combinational path from the inputs to the outputs.
//
// STRUCTURE
//   - div_pkg: typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t; localparam ITER_W = $clog2(DATA_WIDTH)+1.
//   - Single module; the iteration datapath is one always_ff, with the fix-up in an always_comb.
//   - No sub-module is needed; the sign handling is too small to justify one.
//
// TESTING
//   - Unsigned 100/7, is_unsigned=1 -> q=14, r=2; is_finished high exactly in cycle 33, for one cycle.
//   - Signed -7/2 (0xFFFFFFF9/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//   - Signed 7/-2 -> q=0xFFFFFFFD, r=1.
//   - 5/0, both modes -> q=0xFFFFFFFF, r=5; is_finished in cycle 1.
//   - Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; is_finished in cycle 1.
//   - Unsigned 0x80000000/0xFFFFFFFF -> q=0, r=0x80000000; full latency.
//   - Abort: drop triggered at cycle 10 -> IDLE at cycle 11, no is_finished.
//       - Then retrigger 9/3 -> q=3, r=0 at start+33.
//   - hold=1 for 4 cycles in DONE -> is_finished and results stay stable all 4 cycles, then IDLE.
//   - Back-to-back 20/4 then 21/4 with triggered kept high -> 5,0 then 5,1; the second start is the cycle after DONE.
//   - rst_n=0 at cycle 15 of BUSY -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package iter_divider_pkg;

  localparam int DIV_DW = 32;

  // Counter width needed to count DATA_WIDTH iterations.
  function automatic int iter_w(input int dw);
    return $clog2(dw) + 1;
  endfunction

  localparam int ITER_W = iter_w(DIV_DW);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/iter_divider_if.sv
// Divide handshake between the execute stage (master) and the divider (slave).
interface iter_divider_if
  import iter_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DW
);
  logic                  triggered;
  logic                  hold;
  logic                  is_unsigned;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  is_finished;
  logic                  busy;

  modport master (
    output triggered, hold, is_unsigned, dividend, divisor,
    input  quotient, remainder, is_finished, busy
  );

  modport slave (
    input  triggered, hold, is_unsigned, dividend, divisor,
    output quotient, remainder, is_finished, busy
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider with RV32M DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; divide-by-zero and signed overflow finish
// on the start cycle.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_divider_if.slave bus
);

  localparam int CW = iter_w(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONE = {DATA_WIDTH{1'b1}};

  div_state_t            state_q;
  logic [DATA_WIDTH-1:0] quo_q;        // dividend shifting out, quotient shifting in
  logic [DATA_WIDTH-1:0] rem_q;        // partial remainder, always < divisor
  logic [DATA_WIDTH-1:0] dvs_q;        // divisor magnitude
  logic [CW-1:0]         cnt_q;
  logic                  q_neg_q;
  logic                  r_neg_q;
  logic [DATA_WIDTH-1:0] quotient_q;
  logic [DATA_WIDTH-1:0] remainder_q;
  logic                  fin_q;

  logic                  sgn_a, sgn_b;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic [DATA_WIDTH:0]   rem_sh, diff;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_nx, quo_nx;
  logic [DATA_WIDTH-1:0] q_fix, r_fix;

  // Operand signs and magnitudes; unsigned mode passes raw values through.
  always_comb begin
    sgn_a = ~bus.is_unsigned & bus.dividend[DATA_WIDTH-1];
    sgn_b = ~bus.is_unsigned & bus.divisor[DATA_WIDTH-1];
    mag_a = sgn_a ? -bus.dividend : bus.dividend;
    mag_b = sgn_b ? -bus.divisor  : bus.divisor;
  end

  // One restoring step; the borrow out of the wide subtract is the compare.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = ~diff[DATA_WIDTH];
    rem_nx = ge ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    quo_nx = {quo_q[DATA_WIDTH-2:0], ge};
  end

  // Sign fix-up applied to the final step's result.
  always_comb begin
    q_fix = q_neg_q ? -quo_nx : quo_nx;
    r_fix = r_neg_q ? -rem_nx : rem_nx;
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      fin_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.triggered) begin
            if (bus.divisor == '0) begin
              quotient_q  <= ALL_ONE;
              remainder_q <= bus.dividend;
              fin_q       <= 1'b1;
              state_q     <= DONE;
            end else if (!bus.is_unsigned && bus.dividend == MIN_NEG &&
                         bus.divisor == ALL_ONE) begin
              quotient_q  <= MIN_NEG;
              remainder_q <= '0;
              fin_q       <= 1'b1;
              state_q     <= DONE;
            end else begin
              quo_q   <= mag_a;
              dvs_q   <= mag_b;
              rem_q   <= '0;
              cnt_q   <= '0;
              q_neg_q <= sgn_a ^ sgn_b;
              r_neg_q <= sgn_a;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!bus.triggered) begin
            // Flushed by execute: drop the operation, keep old results.
            state_q <= IDLE;
          end else begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH-1)) begin
              quotient_q  <= q_fix;
              remainder_q <= r_fix;
              fin_q       <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (!bus.hold) begin
            fin_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.is_finished = fin_q;
  assign bus.busy        = (state_q == BUSY);

endmodule

// File: tb/tb_iter_divider.sv
// Directed and random checks of iter_divider against an arithmetic model.
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iter_divider_if #(.DATA_WIDTH(32)) bus ();
  iter_divider #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain integer arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit u,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
    int sa, sb;
    lat = 33;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (u) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; lat = 1;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit u);
    bus.dividend    = a;
    bus.divisor     = b;
    bus.is_unsigned = u;
    bus.triggered   = 1'b1;
  endtask

  // Count edges until is_finished; -1 if it never comes within the budget.
  task automatic wait_fin(input bit scramble, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (scramble) begin
        bus.dividend    = $urandom;
        bus.divisor     = $urandom;
        bus.is_unsigned = 1'($urandom_range(0, 1));
      end
      if (bus.is_finished === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit u, input string tag);
    logic [31:0] eq, er;
    int el, n;
    ref_div(a, b, u, eq, er, el);
    start_op(a, b, u);
    wait_fin(1'b1, n);
    check({tag, " latency"}, n, el);
    check({tag, " quotient"}, bus.quotient, eq);
    check({tag, " remainder"}, bus.remainder, er);
    last_q = eq;
    last_r = er;
    bus.triggered = 1'b0;
    tick();
    check({tag, " fin one cycle"}, {31'd0, bus.is_finished}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] eq, er, a, b;
    int el, n;
    bit saw_fin, u;

    rst_n = 1'b0;
    bus.triggered = 1'b0; bus.hold = 1'b0; bus.is_unsigned = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    repeat (3) tick();
    check("reset quotient", bus.quotient, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    check("reset fin", {31'd0, bus.is_finished}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle busy", {31'd0, bus.busy}, 32'd0);

    run_div(32'd100, 32'd7, 1'b1, "u100/7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "s-7/2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b0, "s7/-2");
    run_div(32'd5, 32'd0, 1'b1, "u5/0");
    run_div(32'd5, 32'd0, 1'b0, "s5/0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s ovf");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "u big");

    // Abort: drop triggered after cycle 10.
    start_op(32'd123456, 32'd77, 1'b0);
    saw_fin = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.is_finished === 1'b1) saw_fin = 1'b1;
    end
    check("abort busy before", {31'd0, bus.busy}, 32'd1);
    bus.triggered = 1'b0;
    tick();
    check("abort no fin", {31'd0, saw_fin | bus.is_finished}, 32'd0);
    check("abort idle", {31'd0, bus.busy}, 32'd0);
    check("abort q kept", bus.quotient, last_q);
    check("abort r kept", bus.remainder, last_r);
    run_div(32'd9, 32'd3, 1'b1, "retrig 9/3");

    // Hold in DONE for four cycles.
    bus.hold = 1'b1;
    ref_div(32'd1000, 32'hFFFF_FFFD, 1'b0, eq, er, el);
    start_op(32'd1000, 32'hFFFF_FFFD, 1'b0);
    wait_fin(1'b0, n);
    check("hold latency", n, el);
    for (int k = 0; k < 4; k++) begin
      check("hold fin", {31'd0, bus.is_finished}, 32'd1);
      check("hold q", bus.quotient, eq);
      check("hold r", bus.remainder, er);
      if (k == 3) begin
        bus.hold = 1'b0;
        bus.triggered = 1'b0;
      end
      tick();
    end
    check("hold release fin", {31'd0, bus.is_finished}, 32'd0);
    check("hold release busy", {31'd0, bus.busy}, 32'd0);

    // Back-to-back with triggered held high.
    start_op(32'd20, 32'd4, 1'b1);
    wait_fin(1'b0, n);
    check("b2b1 latency", n, 33);
    check("b2b1 q", bus.quotient, 32'd5);
    check("b2b1 r", bus.remainder, 32'd0);
    bus.dividend = 32'd21;
    tick();
    check("b2b idle fin", {31'd0, bus.is_finished}, 32'd0);
    check("b2b idle busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("b2b2 busy", {31'd0, bus.busy}, 32'd1);
    wait_fin(1'b0, n);
    check("b2b2 latency", n, 32);
    check("b2b2 q", bus.quotient, 32'd5);
    check("b2b2 r", bus.remainder, 32'd1);
    bus.triggered = 1'b0;
    tick();

    // Random operations.
    for (int t = 0; t < 24; t++) begin
      u = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = (t % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      run_div(a, b, u, "random");
    end

    // Reset during BUSY.
    start_op(32'hDEAD_BEEF, 32'h1234, 1'b1);
    repeat (15) tick();
    check("mid busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid rst busy", {31'd0, bus.busy}, 32'd0);
    check("mid rst fin", {31'd0, bus.is_finished}, 32'd0);
    check("mid rst q", bus.quotient, 32'd0);
    check("mid rst r", bus.remainder, 32'd0);
    rst_n = 1'b1;
    bus.triggered = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
